// File: rtl/conv_sched_if.sv
// conv_sched_if: handshake and datapath-control bundle for conv_sched.
//
// Signal groups:
//   command   : cmd_valid, cmd_ready, cmd_layer
//   weights   : wt_rd, wt_addr, wt_rdata, weight_en, weight
//   run ctrl  : layer, win_start, conv_start, conv_ovalid, conv_done
//   status    : ch_idx, busy, done, cnt_err
//
// Modports:
//   master : the sequencer side (conv_sched drives the outputs)
//   slave  : the environment side (layer controller, weight memory, conv)
interface conv_sched_if #(
  parameter int WA_W = 8
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_layer;
  logic            layer;
  logic            wt_rd;
  logic [WA_W-1:0] wt_addr;
  logic            wt_rdata;
  logic            weight_en;
  logic            weight;
  logic            win_start;
  logic            conv_start;
  logic            conv_ovalid;
  logic            conv_done;
  logic [3:0]      ch_idx;
  logic            busy;
  logic            done;
  logic            cnt_err;

  modport master (
    input  cmd_valid, cmd_layer, wt_rdata, conv_ovalid, conv_done,
    output cmd_ready, layer, wt_rd, wt_addr, weight_en, weight,
           win_start, conv_start, ch_idx, busy, done, cnt_err
  );

  modport slave (
    output cmd_valid, cmd_layer, wt_rdata, conv_ovalid, conv_done,
    input  cmd_ready, layer, wt_rd, wt_addr, weight_en, weight,
           win_start, conv_start, ch_idx, busy, done, cnt_err
  );
endinterface

// File: rtl/conv_sched.sv
// conv_sched: per-layer channel sequencer for the binary 3x3 conv engine
// and its sliding-window feeder.
//
// For every output channel of the commanded layer it streams the K*K-bit
// kernel from weight memory into the conv engine, raises win_start and
// (START_DLY cycles later) conv_start, waits for conv_done, then moves on.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : conv_sched_if.master (command, weight fetch, run control, status)
//
// Optional feature (macro CONV_SCHED_CNT_CHECK_EN):
//   counts conv_ovalid strobes during each run and compares the total at
//   conv_done against the expected output-map size; a mismatch sets the
//   sticky cnt_err flag. Without the macro cnt_err is tied low.
module conv_sched #(
  parameter int K         = 3,
  parameter int CH_L0     = 6,
  parameter int CH_L1     = 12,
  parameter int WA_W      = 8,
  parameter int START_DLY = 2
) (
  input  logic         clk,
  input  logic         rst,
  conv_sched_if.master bus
);

  localparam int KK  = K * K;
  localparam int J_W = $clog2(KK + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_GAP, S_NEXT, S_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [J_W-1:0]  j_q, j_d;       // LOAD beat index 0..KK
  logic [3:0]      ch_q, ch_d;
  logic            layer_q, layer_d;
  logic [3:0]      dly_q, dly_d;   // cycles since RUN entry, saturating

  logic            accept;
  logic            load_last;
  logic [3:0]      last_ch;
  logic [WA_W-1:0] base_a;
  logic [WA_W-1:0] addr_a;

  assign accept    = bus.cmd_valid && (state_q == S_IDLE);
  assign load_last = (j_q == J_W'(KK));
  assign last_ch   = layer_q ? 4'(CH_L1 - 1) : 4'(CH_L0 - 1);
  assign base_a    = layer_q ? WA_W'(CH_L0 * KK) : '0;
  assign addr_a    = base_a + WA_W'(ch_q) * WA_W'(KK) + WA_W'(j_q);

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_d = state_q;
    j_d     = j_q;
    ch_d    = ch_q;
    layer_d = layer_q;
    dly_d   = dly_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          layer_d = bus.cmd_layer;
          ch_d    = '0;
          j_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_last) begin
          dly_d   = '0;
          state_d = S_RUN;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_RUN: begin
        if (dly_q != 4'(START_DLY)) dly_d = dly_q + 4'd1;
        // An early conv_done (before conv_start rises) still ends the run.
        if (bus.conv_done) state_d = S_GAP;
      end
      S_GAP:  state_d = S_NEXT;
      S_NEXT: begin
        if (ch_q == last_ch) begin
          state_d = S_FIN;
        end else begin
          ch_d    = ch_q + 4'd1;
          j_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      ch_q    <= '0;
      layer_q <= 1'b0;
      dly_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from the same
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      j_q     <= j_d;
      ch_q    <= ch_d;
      layer_q <= layer_d;
      dly_q   <= dly_d;
    end
  end

`ifdef CONV_SCHED_CNT_CHECK_EN
  localparam int IN_L0 = 28;
  localparam int IN_L1 = 12;

  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [15:0] exp_cnt;
  logic [15:0] cnt_at_done;

  assign exp_cnt     = layer_q ? 16'((IN_L1 - K + 1) ** 2) : 16'((IN_L0 - K + 1) ** 2);
  // An ovalid coincident with conv_done belongs to this run.
  assign cnt_at_done = cnt_q + {15'd0, bus.conv_ovalid};

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept) err_d = 1'b0;
    if (state_q == S_LOAD && load_last) cnt_d = '0;
    if (state_q == S_RUN) begin
      if (bus.conv_ovalid) cnt_d = cnt_q + 16'd1;
      if (bus.conv_done && cnt_at_done != exp_cnt) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.cnt_err = err_q;
`else
  logic unused_ovalid;
  assign unused_ovalid = bus.conv_ovalid;
  assign bus.cnt_err   = 1'b0;
`endif

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.layer      = layer_q;
  assign bus.ch_idx     = ch_q;
  assign bus.done       = (state_q == S_FIN);
  assign bus.weight_en  = (state_q == S_LOAD);
  assign bus.wt_rd      = (state_q == S_LOAD) && !load_last;
  assign bus.wt_addr    = bus.wt_rd ? addr_a : '0;
  // Read data lags the strobe by one cycle, so beat 0 carries a dummy 0.
  assign bus.weight     = (state_q == S_LOAD) && (j_q != '0) && bus.wt_rdata;
  assign bus.win_start  = (state_q == S_RUN);
  assign bus.conv_start = (state_q == S_RUN) && (dly_q == 4'(START_DLY));

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: self-checking bench for conv_sched.
// Table of layer jobs (inputs + expected per-layer values) applied in a loop;
// each job walks every channel cycle by cycle against hand-derived values.
// Hand sequences cover reset state and the mid-RUN reset.
module tb_conv_sched;
  localparam int K         = 3;
  localparam int KK        = K * K;
  localparam int CH_L0     = 6;
  localparam int CH_L1     = 12;
  localparam int WA_W      = 8;
  localparam int START_DLY = 2;

`ifdef CONV_SCHED_CNT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    // stimulus
    logic lay;
    int   bad_ch;    // channel returning bad_n ovalids (-1: none)
    int   bad_n;     // 0 means conv_done at RUN entry, before conv_start
    bit   coinc;     // last ovalid coincides with conv_done
    bit   hold;      // keep cmd_valid high for the whole job
    bit   stray;     // stray conv_done/ovalid during LOAD
    int   abort_ch;  // assert rst on RUN entry of this channel (-1: none)
    // expected
    int   exp_nch;
    int   exp_base;
    int   exp_nov;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[5];

  always #5 clk = ~clk;

  conv_sched_if #(.WA_W(WA_W)) sif ();

  conv_sched #(
    .K(K), .CH_L0(CH_L0), .CH_L1(CH_L1), .WA_W(WA_W), .START_DLY(START_DLY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.master)
  );

  // Weight memory: bit = addr[0], one-cycle read latency.
  always @(posedge clk) sif.wt_rdata <= sif.wt_rd ? sif.wt_addr[0] : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},       32'(sif.busy),       0);
    check({tag, "_cmd_ready"},  32'(sif.cmd_ready),  1);
    check({tag, "_win_start"},  32'(sif.win_start),  0);
    check({tag, "_conv_start"}, 32'(sif.conv_start), 0);
    check({tag, "_weight_en"},  32'(sif.weight_en),  0);
    check({tag, "_wt_rd"},      32'(sif.wt_rd),      0);
    check({tag, "_ch_idx"},     32'(sif.ch_idx),     0);
    check({tag, "_done"},       32'(sif.done),       0);
    check({tag, "_cnt_err"},    32'(sif.cnt_err),    0);
  endtask

  task automatic run_job(input vec_t v);
    logic       err_seen;
    logic [9:0] wseq;
    int         a;
    int         n;
    err_seen = 1'b0;
    @(negedge clk);
    sif.cmd_valid = 1'b1;
    sif.cmd_layer = v.lay;
    @(negedge clk);  // accepted: LOAD beat 0
    check("acc_busy",    32'(sif.busy),    1);
    check("acc_layer",   32'(sif.layer),   32'(v.lay));
    check("acc_cnt_err", 32'(sif.cnt_err), 0);
    if (!v.hold) sif.cmd_valid = 1'b0;

    for (int c = 0; c < v.exp_nch; c++) begin
      wseq = '0;
      for (int j = 0; j <= KK; j++) begin
        a = v.exp_base + c * KK + j;
        check("ld_ch_idx",    32'(sif.ch_idx),    c);
        check("ld_weight_en", 32'(sif.weight_en), 1);
        check("ld_wt_rd",     32'(sif.wt_rd),     32'(j < KK));
        if (j < KK) check("ld_wt_addr", 32'(sif.wt_addr), a);
        check("ld_weight",    32'(sif.weight),    (j == 0) ? 0 : ((a - 1) & 1));
        check("ld_cmd_ready", 32'(sif.cmd_ready), 0);
        check("ld_win_start", 32'(sif.win_start), 0);
        wseq = {wseq[8:0], sif.weight};
        if (v.stray) begin
          sif.conv_done   = (j == 3);
          sif.conv_ovalid = (j == 3);
        end
        @(negedge clk);
      end
      if (v.lay && c == 0) check("l1_first_weights", 32'(wseq), 32'h0AA);

      // RUN entry
      check("run_weight_en",  32'(sif.weight_en),  0);
      check("run_win_start",  32'(sif.win_start),  1);
      check("run_conv_start", 32'(sif.conv_start), 0);

      if (c == v.abort_ch) begin
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_abort");
        sif.cmd_valid = 1'b0;
        return;
      end

      n = (c == v.bad_ch) ? v.bad_n : v.exp_nov;
      if (n == 0) begin
        sif.conv_done = 1'b1;
        @(negedge clk);
        sif.conv_done = 1'b0;
      end else begin
        for (int d = 1; d <= START_DLY; d++) begin
          @(negedge clk);
          check("dly_conv_start", 32'(sif.conv_start), 32'(d == START_DLY));
          check("dly_win_start",  32'(sif.win_start),  1);
        end
        for (int i = 0; i < n; i++) begin
          sif.conv_ovalid = 1'b1;
          sif.conv_done   = v.coinc && (i == n - 1);
          @(negedge clk);
        end
        sif.conv_ovalid = 1'b0;
        if (!v.coinc) begin
          sif.conv_done = 1'b1;
          @(negedge clk);
        end
        sif.conv_done = 1'b0;
      end
      if (n != v.exp_nov) err_seen = 1'b1;

      // GAP
      check("gap_win_start",  32'(sif.win_start),  0);
      check("gap_conv_start", 32'(sif.conv_start), 0);
      check("gap_busy",       32'(sif.busy),       1);
      check("gap_cnt_err",    32'(sif.cnt_err),    32'(CHK_EN && err_seen));
      @(negedge clk);
      // NEXT
      check("next_win_start", 32'(sif.win_start), 0);
      check("next_done",      32'(sif.done),      0);
      check("next_ch_idx",    32'(sif.ch_idx),    c);
      @(negedge clk);
    end

    // FIN
    check("fin_done",      32'(sif.done),      1);
    check("fin_ch_idx",    32'(sif.ch_idx),    v.exp_nch - 1);
    check("fin_cmd_ready", 32'(sif.cmd_ready), 0);
    check("fin_cnt_err",   32'(sif.cnt_err),   32'(CHK_EN && err_seen));
    @(negedge clk);
    check("idle_cmd_ready", 32'(sif.cmd_ready), 1);
    check("idle_busy",      32'(sif.busy),      0);
    check("idle_done",      32'(sif.done),      0);
    sif.cmd_valid = 1'b0;
  endtask

  initial begin
    //         lay   bad_ch bad_n coinc hold stray abort nch    base         nov
    vecs[0] = '{1'b0, -1,    0,    1'b0, 1'b1, 1'b1, -1, CH_L0, 0,          676};
    vecs[1] = '{1'b1,  3,    99,   1'b1, 1'b0, 1'b0, -1, CH_L1, CH_L0 * KK, 100};
    vecs[2] = '{1'b1,  0,    0,    1'b0, 1'b0, 1'b0, -1, CH_L1, CH_L0 * KK, 100};
    vecs[3] = '{1'b1, -1,    0,    1'b1, 1'b0, 1'b0,  5, CH_L1, CH_L0 * KK, 100};
    vecs[4] = '{1'b0,  2,    677,  1'b1, 1'b0, 1'b0, -1, CH_L0, 0,          676};

    rst             = 1'b1;
    sif.cmd_valid   = 1'b0;
    sif.cmd_layer   = 1'b0;
    sif.conv_ovalid = 1'b0;
    sif.conv_done   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("released");

    for (int t = 0; t < 5; t++) run_job(vecs[t]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Sequencer for the binary 3x3 convolution datapath and its sliding-window feeder.
- On a layer command, loops over every output channel of that layer. For each channel it:
  - fetches the K*K one-bit kernel from weight memory;
  - streams the kernel serially into the conv engine via weight_en/weight;
  - starts window and conv;
  - waits for conv_done, then advances to the next channel.
- Sits between the top-level layer controller and the conv/window pair.

Parameters:
- K, 3: kernel side; kernel has K*K bits.
- CH_L0, 6: output channels of layer 0 (28x28 input).
- CH_L1, 12: output channels of layer 1 (12x12 input).
- WA_W, 8: weight memory address width; layer-1 kernels start at CH_L0*K*K.
- START_DLY, 2: cycles between win_start rising and conv_start rising (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  layer command request
- cmd_ready  out  1  high only in IDLE
- cmd_layer  in  1  0 = layer 0, 1 = layer 1; sampled on handshake
- layer  out  1  registered layer select to window/conv
- wt_rd  out  1  weight memory read strobe
- wt_addr  out  WA_W  weight memory address
- wt_rdata  in  1  weight bit; valid 1 cycle after wt_rd
- weight_en  out  1  kernel load enable to conv
- weight  out  1  serial kernel bit to conv
- win_start  out  1  sliding-window run level
- conv_start  out  1  conv run level
- conv_ovalid  in  1  conv output-valid strobe
- conv_done  in  1  conv completion pulse
- ch_idx  out  4  current output channel
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when all channels of a layer are finished
- cnt_err  out  1  sticky output-count mismatch flag

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. FSM goes to IDLE, counters clear.
- Reset mid-operation aborts immediately, with the same values on the next edge after release.
- Handshake: accept when cmd_valid && cmd_ready. On accept:
  - layer <= cmd_layer, ch_idx <= 0, cnt_err <= 0;
  - nch = CH_L0 or CH_L1 according to layer;
  - go to LOAD.
- cmd_valid while busy is ignored; no queueing.
- LOAD: exactly K*K+1 cycles, index j = 0..K*K. weight_en=1 on all of them.
  - wt_rd=1 for j = 0..K*K-1, with wt_addr = base + ch_idx*K*K + j.
  - base = 0 for layer 0, CH_L0*K*K for layer 1.
  - weight = 0 at j=0; weight = wt_rdata at j >= 1, so tap order is k00..k22 row-major.
  - Then weight_en=0 and go to RUN.
- RUN:
  - win_start=1 on entry.
  - conv_start=1 from START_DLY cycles after entry.
  - Both are held until conv_done is sampled high.
  - conv_done arriving before conv_start has risen is still honoured.
- Output counter (16 bit):
  - cleared on RUN entry;
  - increments on conv_ovalid in RUN;
  - conv_ovalid outside RUN is ignored.
- On conv_done in RUN:
  - drop win_start and conv_start on the next edge;
  - go to GAP for 1 cycle, so both starts are low at least one cycle (conv cycle counter clears).
- GAP -> NEXT. In NEXT:
  - if ch_idx == nch-1, go to FIN;
  - else ch_idx++ and go to LOAD.
- FIN: done=1 for one cycle, then IDLE. cmd_ready rises the cycle after done.
- conv_done outside RUN is ignored.
- Cycle count per channel, excluding the conv run time: K*K+1 (LOAD) + RUN + 1 (GAP) + 1 (NEXT).

Optional Feature:
- Macro: CONV_SCHED_CNT_CHECK_EN.
- With the macro defined, at conv_done the output counter is compared to the expected count:
  - (28-K+1)^2 = 676 for layer 0;
  - (12-K+1)^2 = 100 for layer 1.
  - The compare includes an ovalid coincident with conv_done.
  - Any mismatch sets cnt_err, which stays set until the next accepted command or rst.
- Without the macro: no counter logic; cnt_err is tied 0.

Test Plan:
- rst asserted mid-RUN on layer 1, ch 5 -> next edge: busy=0, win_start=0, conv_start=0, weight_en=0, cmd_ready=1, ch_idx=0.
- Layer 0 command, model conv returns 676 ovalids then conv_done per channel -> exactly 6 LOAD bursts:
  - wt_addr 0..8, 9..17, ..., 45..53;
  - done pulses once after ch_idx=5;
  - cnt_err=0.
- Layer 1 command with memory bits = addr[0] -> first burst:
  - wt_addr 54..62;
  - weight sequence over 10 weight_en cycles = 0,0,1,0,1,0,1,0,1,0;
  - 12 channels, then done.
- START_DLY=2 -> conv_start rises exactly 2 cycles after win_start; after conv_done both are low for >= 1 cycle before the next LOAD.
- cmd_valid held high throughout a layer-0 job -> no second accept until the cycle after done; stray conv_done/ovalid in LOAD are ignored.
- With CONV_SCHED_CNT_CHECK_EN, layer 1 channel 3 returns 99 ovalids -> cnt_err=1 from the edge after conv_done, still 1 at done, cleared on the next accept.
